// File: rtl/ex_hilo_unit.sv
// EX-stage HI/LO unit: mult/multu and mthi/mtlo in one cycle; madd/msub in two passes with one stall.
// div/divu need HILO_DIV_EN and take 34 cycles (3 for a zero divisor). Outputs combinational, results in DIV_END.
module ex_hilo_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [63:0] hilo_temp_i,
   input  logic [1:0]  cnt_i,
   input  logic        annul_i,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [63:0] hilo_temp_o,
   output logic [1:0]  cnt_o,
   output logic        stallreq_o
);
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
   localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
   localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
   localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
   localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] acc_res;
   logic        acc_signed;
   logic        acc_sub;

   // Low 64 bits of the product of the sign-extended operands is the signed product
   assign prod_s     = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
   assign prod_u     = {32'd0, reg1_i} * {32'd0, reg2_i};
   assign acc_signed = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
   assign acc_sub    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
   assign acc_res    = acc_sub ? ({hi_i, lo_i} - hilo_temp_i) : ({hi_i, lo_i} + hilo_temp_i);

`ifdef HILO_DIV_EN
   typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_t;

   div_state_t  div_state;
   logic [31:0] div_dvd;
   logic [31:0] div_rem;
   logic [31:0] div_dvs;
   logic [4:0]  div_iter;
   logic        div_neg_q;
   logic        div_neg_r;
   logic        div_start;
   logic        div_signed;
   logic [32:0] trial_rem;
   logic [31:0] trial_diff;
   logic        trial_ge;
   logic [31:0] div_q;
   logic [31:0] div_r;

   assign div_signed = (aluop_i == EXE_DIV_OP);
   assign div_start  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

   // The true difference is below the divisor, so 32 bits hold it exactly
   assign trial_rem  = {div_rem, div_dvd[31]};
   assign trial_diff = trial_rem[31:0] - div_dvs;
   assign trial_ge   = (trial_rem >= {1'b0, div_dvs});

   assign div_q = div_neg_q ? -div_dvd : div_dvd;
   assign div_r = div_neg_r ? -div_rem : div_rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_state <= DIV_FREE;
         div_dvd   <= '0;
         div_rem   <= '0;
         div_dvs   <= '0;
         div_iter  <= '0;
         div_neg_q <= 1'b0;
         div_neg_r <= 1'b0;
      end else if (annul_i) begin
         div_state <= DIV_FREE;
      end else begin
         case (div_state)
            DIV_FREE: begin
               if (div_start) begin
                  if (reg2_i == 32'd0) begin
                     div_state <= DIV_BY_ZERO;
                  end else begin
                     div_dvd   <= (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
                     div_dvs   <= (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;
                     div_rem   <= '0;
                     div_iter  <= '0;
                     div_neg_q <= div_signed && (reg1_i[31] ^ reg2_i[31]);
                     div_neg_r <= div_signed && reg1_i[31];
                     div_state <= DIV_ON;
                  end
               end
            end
            DIV_BY_ZERO: begin
               div_dvd   <= '0;
               div_rem   <= '0;
               div_neg_q <= 1'b0;
               div_neg_r <= 1'b0;
               div_state <= DIV_END;
            end
            DIV_ON: begin
               // Dividend bits shift out the top while quotient bits shift in the bottom
               div_dvd  <= {div_dvd[30:0], trial_ge};
               div_rem  <= trial_ge ? trial_diff : trial_rem[31:0];
               div_iter <= div_iter + 5'd1;
               if (div_iter == 5'd31) begin
                  div_state <= DIV_END;
               end
            end
            DIV_END: begin
               div_state <= DIV_FREE;
            end
            default: begin
               div_state <= DIV_FREE;
            end
         endcase
      end
   end
`else
   logic unused_div_inputs;
   assign unused_div_inputs = ^{clk, rst, annul_i};
`endif

   always_comb begin
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
      hilo_temp_o = '0;
      cnt_o       = '0;
      stallreq_o  = 1'b0;
      case (aluop_i)
         EXE_MULT_OP: begin
            {hi_o, lo_o} = prod_s;
            whilo_o      = 1'b1;
         end
         EXE_MULTU_OP: begin
            {hi_o, lo_o} = prod_u;
            whilo_o      = 1'b1;
         end
         EXE_MTHI_OP: begin
            hi_o    = reg1_i;
            lo_o    = lo_i;
            whilo_o = 1'b1;
         end
         EXE_MTLO_OP: begin
            hi_o    = hi_i;
            lo_o    = reg1_i;
            whilo_o = 1'b1;
         end
         EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
            // Any counter value other than 1 restarts at the product pass
            if (cnt_i == 2'd1) begin
               {hi_o, lo_o} = acc_res;
               cnt_o        = 2'd2;
               whilo_o      = 1'b1;
            end else begin
               hilo_temp_o = acc_signed ? prod_s : prod_u;
               cnt_o       = 2'd1;
               stallreq_o  = 1'b1;
            end
         end
`ifdef HILO_DIV_EN
         EXE_DIV_OP, EXE_DIVU_OP: begin
            if (!annul_i) begin
               if (div_state == DIV_END) begin
                  hi_o    = div_r;
                  lo_o    = div_q;
                  whilo_o = 1'b1;
               end else begin
                  stallreq_o = 1'b1;
               end
            end
         end
`endif
         default: begin
            whilo_o = 1'b0;
         end
      endcase
   end
endmodule

// File: doc/ex_hilo_unit.md
# ex_hilo_unit

Execute-stage HI/LO arithmetic unit, directly upstream of `ex_mem`. It produces the `ex_whilo`/`ex_hi`/`ex_lo` write bundle, the multi-cycle accumulate feedback (`hilo_i`/`cnt_i` loop through `ex_mem`), and the EX stall request. Covers mult/multu, madd/maddu/msub/msubu (two-pass), mthi/mtlo and div/divu (32-iteration radix-2 divider FSM).

## Interface
No parameters; widths come from `defines.v` (`RegBus` = 32, `DoubleRegBus` = 64).

Reset is asynchronous, active-low: `rst` = 0 resets the divider FSM.

- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- aluop_i  in  8  EX operation code, `EXE_*_OP` encodings from `defines.v`
- reg1_i  in  32  operand A / dividend (rs)
- reg2_i  in  32  operand B / divisor (rt)
- hi_i, lo_i  in  32 each  forwarded current HI/LO
- hilo_temp_i  in  64  partial product fed back from `ex_mem.hilo_o`
- cnt_i  in  2  pass counter fed back from `ex_mem.cnt_o`
- annul_i  in  1  flush; aborts an in-flight divide
- whilo_o  out  1  HI/LO write enable, to `ex_mem.ex_whilo`
- hi_o, lo_o  out  32 each  HI/LO write data
- hilo_temp_o  out  64  partial product, to `ex_mem.hilo_i`
- cnt_o  out  2  pass counter, to `ex_mem.cnt_i`
- stallreq_o  out  1  EX stall request to the stall controller

## Operation

**Output defaults.** Outputs are combinational from inputs and FSM state. Unless an op overrides them, every output is 0.

**Single-cycle ops**
- mult/multu: `{hi_o, lo_o}` = signed/unsigned 64-bit product; `whilo_o` = 1.
- mthi: `hi_o` = reg1_i, `lo_o` = lo_i, `whilo_o` = 1.
- mtlo: `lo_o` = reg1_i, `hi_o` = hi_i, `whilo_o` = 1.

**madd/maddu/msub/msubu (two passes)**
- Pass 1, `cnt_i` = 0:
  - `hilo_temp_o` = product (signed for madd/msub, unsigned for maddu/msubu).
  - `cnt_o` = 1, `stallreq_o` = 1, `whilo_o` = 0.
- Pass 2, `cnt_i` = 1:
  - `{hi_o, lo_o}` = `{hi_i, lo_i}` + `hilo_temp_i` (madd/maddu), or − `hilo_temp_i` (msub/msubu), modulo 2^64.
  - `cnt_o` = 2, `stallreq_o` = 0, `whilo_o` = 1.
- `cnt_i` = 2 or 3 with an accumulate op: treated as pass 1 (defensive).

**div/divu FSM**
- States: `DIV_FREE`, `DIV_BY_ZERO`, `DIV_ON`, `DIV_END`.
- `DIV_FREE`, div op seen and `annul_i` = 0:
  - If reg2_i = 0, go to `DIV_BY_ZERO`.
  - Otherwise latch the operands (absolute values for div), clear the remainder and iteration counter, latch the sign flags, and go to `DIV_ON`.
- `DIV_BY_ZERO`: go to `DIV_END` with result 0/0.
- `DIV_ON`:
  - Each cycle performs one restoring iteration (shift remainder/dividend, trial subtract of the 33-bit remainder, set quotient bit).
  - After 32 iterations, go to `DIV_END`.
- `DIV_END`:
  - `whilo_o` = 1, `lo_o` = quotient, `hi_o` = remainder.
  - Next state is `DIV_FREE`.
- Signed correction for div:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- `stallreq_o` = 1 for a div op in `DIV_FREE`, `DIV_BY_ZERO` and `DIV_ON`; 0 in `DIV_END`.
- `annul_i` = 1 in any state: next state is `DIV_FREE`, `whilo_o` = 0, `stallreq_o` = 0.
- Reset (`rst` = 0) at any time: state goes to `DIV_FREE` and all divider registers clear, taking effect immediately.

## Timing
- Single-cycle ops: 0 extra cycles.
- Accumulate ops: 1 stall cycle. Pass-1 data is captured by `ex_mem` on the stall edge and returns as `hilo_temp_i`/`cnt_i` on the next cycle.
- Divide, nonzero divisor: 34 EX cycles (1 `DIV_FREE` + 32 `DIV_ON` + 1 `DIV_END`), with 33 of them stalled.
- Divide by zero: 3 EX cycles, with 2 of them stalled.
- The result is valid only in `DIV_END`. `ex_mem` captures it at the end of that cycle, and the FSM is back in `DIV_FREE` for the next instruction.
- Back-to-back divides: the second starts in the cycle after `DIV_END`, with no bubble.

## Configuration
- `HILO_DIV_EN`
  - Defined: the divider FSM is built as specified above.
  - Undefined: the FSM and its registers are omitted. div/divu give `whilo_o` = 0 and `stallreq_o` = 0 (executed as a no-op), and all other ops are unchanged.

## Test plan
- mult: reg1 = 0xFFFFFFFE, reg2 = 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, whilo = 1, no stall. multu with the same operands → HI = 0x2, LO = 0xFFFFFFFA.
- madd: HI = 1, LO = 0, reg1 = 3, reg2 = 0xFFFFFFFE, looped through `ex_mem` → one stall cycle, then HI = 0x00000000, LO = 0xFFFFFFFA; cnt returns to 0 after the advance.
- div: −7 / 2 → stall 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu: 0xFFFFFFFF / 0x10 → LO = 0x0FFFFFFF, HI = 0xF.
- div by zero: divisor 0 → 2 stall cycles, then HI = LO = 0 with whilo = 1.
- Abort mid-divide: `annul_i` pulsed at iteration 10 → next cycle FSM is in `DIV_FREE`, stall drops, whilo = 0; a following divu 100 / 7 gives LO = 14, HI = 2.
- Reset mid-divide: `rst` low at iteration 20 → FSM is in `DIV_FREE` immediately; after release, a divu 9 / 3 gives LO = 3, HI = 0 after 34 cycles.
